// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider. It computes a/b in the same Q format as its
// operands, rounding to nearest and saturating the result.
// It uses one restoring step per cycle, so latency is constant and independent of the data.
// Ports:
//   clk, rst         clock and asynchronous active-low reset
//   start_flag       start request, sampled only in IDLE
//   a, b             signed dividend and divisor, captured when a start is accepted
//   Div_result       signed rounded/saturated quotient, held until the next valid
//   valid            one-cycle pulse when Div_result and the flags update
//   busy             high while a division is in flight (DIV and FIN)
//   overflow         result was saturated
//   div_by_zero      divisor was zero
module fixed_point_divider #(
   parameter int unsigned bitsize   = 14,
   parameter int unsigned FRAC_BITS = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_flag,
   input  logic signed [bitsize-1:0] a,
   input  logic signed [bitsize-1:0] b,
   output logic signed [bitsize-1:0] Div_result,
   output logic                      valid,
   output logic                      busy,
   output logic                      overflow,
   output logic                      div_by_zero
);

   localparam int unsigned QW = bitsize + FRAC_BITS;
   localparam int unsigned RW = bitsize + 1;
   localparam int unsigned CW = $clog2(QW);

   localparam logic [QW:0]        MAG_POS_MAX = (QW+1)'((2 ** (bitsize - 1)) - 1);
   localparam logic [QW:0]        MAG_NEG_MAX = (QW+1)'(2 ** (bitsize - 1));
   localparam logic [bitsize-1:0] RES_MAX     = {1'b0, {(bitsize - 1){1'b1}}};
   localparam logic [bitsize-1:0] RES_MIN     = {1'b1, {(bitsize - 1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_t;

   state_t             state_q, state_d;
   logic               sign_q, sign_d;
   logic               bzero_q, bzero_d;
   logic [bitsize-1:0] divisor_q, divisor_d;
   logic [QW-1:0]      dq_q, dq_d;        // dividend shifts out MSB-first, quotient shifts in
   logic [RW-1:0]      rem_q, rem_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [bitsize-1:0] result_q, result_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               ovf_q, ovf_d;
   logic               dz_q, dz_d;

   // Operand magnitudes; the most negative value maps exactly onto 2^(bitsize-1).
   logic [bitsize-1:0] a_abs, b_abs;
   assign a_abs = a[bitsize-1] ? (~a + 1'b1) : a;
   assign b_abs = b[bitsize-1] ? (~b + 1'b1) : b;

   // Restoring step and final rounding arithmetic.
   logic [RW-1:0]      rem_shift, rem_sub;
   logic               step_ge, round_up;
   logic [QW:0]        mag;
   logic [bitsize-1:0] mag_lo;

   assign rem_shift = {rem_q[RW-2:0], dq_q[QW-1]};
   assign step_ge   = rem_shift >= {1'b0, divisor_q};
   assign rem_sub   = rem_shift - {1'b0, divisor_q};
   assign round_up  = {rem_q, 1'b0} >= {2'b00, divisor_q};
   assign mag       = {1'b0, dq_q} + (QW+1)'(round_up);
   assign mag_lo    = mag[bitsize-1:0];

   // Next-state and datapath.
   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      bzero_d   = bzero_q;
      divisor_d = divisor_q;
      dq_d      = dq_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      valid_d   = 1'b0;
      ovf_d     = ovf_q;
      dz_d      = dz_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_flag) begin
               sign_d    = a[bitsize-1] ^ b[bitsize-1];
               bzero_d   = (b == '0);
               divisor_d = b_abs;
               dq_d      = {a_abs, {FRAC_BITS{1'b0}}};
               rem_d     = '0;
               cnt_d     = '0;
               state_d   = S_DIV;
            end
         end
         S_DIV: begin
            rem_d = step_ge ? rem_sub : rem_shift;
            dq_d  = {dq_q[QW-2:0], step_ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(QW - 1)) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            valid_d = 1'b1;
            state_d = S_IDLE;
            dz_d    = bzero_q;
            if (bzero_q) begin
               // Sign equals sign(a) here because b is +0.
               ovf_d    = 1'b1;
               result_d = sign_q ? RES_MIN : RES_MAX;
            end else if (!sign_q && (mag > MAG_POS_MAX)) begin
               ovf_d    = 1'b1;
               result_d = RES_MAX;
            end else if (sign_q && (mag > MAG_NEG_MAX)) begin
               ovf_d    = 1'b1;
               result_d = RES_MIN;
            end else begin
               ovf_d    = 1'b0;
               result_d = sign_q ? (~mag_lo + 1'b1) : mag_lo;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         sign_q    <= 1'b0;
         bzero_q   <= 1'b0;
         divisor_q <= '0;
         dq_q      <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         bzero_q   <= bzero_d;
         divisor_q <= divisor_d;
         dq_q      <= dq_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
         dz_q      <= dz_d;
      end
   end

   assign Div_result  = result_q;
   assign valid       = valid_q;
   assign busy        = busy_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed self-checking bench for fixed_point_divider (Q5.9, 14-bit signed).
module tb_fixed_point_divider;

   logic               clk;
   logic               rst;
   logic               start_flag;
   logic signed [13:0] a;
   logic signed [13:0] b;
   logic signed [13:0] Div_result;
   logic               valid;
   logic               busy;
   logic               overflow;
   logic               div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;

   fixed_point_divider #(.bitsize(14), .FRAC_BITS(9)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_flag  (start_flag),
      .a           (a),
      .b           (b),
      .Div_result  (Div_result),
      .valid       (valid),
      .busy        (busy),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One division: latency, result, flags, single-cycle valid, result hold.
   task automatic run_div(input string tag, input int av, input int bv,
                          input int er, input int eo, input int ez);
      int k;
      bit got;
      @(negedge clk);
      a = 14'(av);
      b = 14'(bv);
      start_flag = 1'b1;
      @(posedge clk);
      #1;
      start_flag = 1'b0;
      a = 14'h1555;
      b = 14'h0AAA;
      chk({tag, "_busy"}, int'(busy), 1);
      got = 1'b0;
      k = 0;
      while (!got && k < 40) begin
         @(posedge clk);
         #1;
         k++;
         if (valid) got = 1'b1;
      end
      chk({tag, "_lat"}, k, 24);
      chk({tag, "_res"}, int'(Div_result), er);
      chk({tag, "_ovf"}, int'(overflow), eo);
      chk({tag, "_dz"}, int'(div_by_zero), ez);
      @(posedge clk);
      #1;
      chk({tag, "_vpulse"}, int'(valid), 0);
      chk({tag, "_idle"}, int'(busy), 0);
      chk({tag, "_hold"}, int'(Div_result), er);
   endtask

   initial begin
      int nv;
      int first_v;
      int second_v;

      rst = 1'b0;
      start_flag = 1'b0;
      a = '0;
      b = '0;
      #12;
      chk("rst_res", int'(Div_result), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_dz", int'(div_by_zero), 0);
      @(negedge clk);
      rst = 1'b1;

      run_div("three",    1536,   512,  1536, 0, 0);
      run_div("third",     512,  1536,   171, 0, 0);
      run_div("nthird",   -512,  1536,  -171, 0, 0);
      run_div("tie",         1,  1024,     1, 0, 0);
      run_div("ntie",       -1,  1024,    -1, 0, 0);
      run_div("ovfp",     4096,   128,  8191, 1, 0);
      run_div("ovfn",    -4096,   128, -8192, 1, 0);
      run_div("dzn",      -100,     0, -8192, 1, 1);
      run_div("dz0",         0,     0,  8191, 1, 1);
      run_div("minmin",  -8192, -8192,   512, 0, 0);
      run_div("minexact",-8192,   512, -8192, 0, 0);
      run_div("maxone",   8191,   512,  8191, 0, 0);
      run_div("negdiv",    100,  -300,  -171, 0, 0);
      run_div("zneg",        0,    -5,     0, 0, 0);

      // Start held high for 30 edges: accepts at edge 0 and 25 only.
      nv = 0;
      first_v = -1;
      second_v = -1;
      @(negedge clk);
      a = 14'sd1536;
      b = 14'sd512;
      start_flag = 1'b1;
      for (int e = 0; e <= 60; e++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            nv++;
            if (first_v < 0) first_v = e;
            else if (second_v < 0) second_v = e;
         end
         if (e == 29) start_flag = 1'b0;
      end
      chk("held_count", nv, 2);
      chk("held_first", first_v, 24);
      chk("held_second", second_v, 49);
      chk("held_res", int'(Div_result), 1536);

      // Reset during DIV step 10 aborts the operation.
      @(negedge clk);
      a = 14'sd512;
      b = 14'sd1536;
      start_flag = 1'b1;
      @(posedge clk);
      #1;
      start_flag = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("abort_res", int'(Div_result), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(valid), 0);
      @(negedge clk);
      rst = 1'b1;
      nv = 0;
      for (int e = 0; e < 30; e++) begin
         @(posedge clk);
         #1;
         if (valid) nv++;
      end
      chk("abort_novalid", nv, 0);
      run_div("after_rst", 512, 1536, 171, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
